// File: rtl/clint_trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
// Optional build macro used by the sequencer: CLINT_VECTORED_EN.
package clint_trap_ctrl_pkg;

  localparam int unsigned CLINT_XLEN = 32;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_HI   = 12;
  localparam int unsigned MSTATUS_MPP_LO   = 11;

  localparam logic [1:0] PRIV_M              = 2'b11;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // mcause codes
  localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'h0000_000B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_MEPC,
    ST_T_MCAUSE,
    ST_T_MSTATUS,
    ST_R_MSTATUS,
    ST_REDIRECT
  } clint_state_e;

endpackage

// File: rtl/clint_mstatus_update.sv
// Combinational mstatus next-value for trap entry (mret=0) and mret (mret=1).
module clint_mstatus_update
  import clint_trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = CLINT_XLEN
) (
  input  logic [XLEN-1:0] mstatus,
  input  logic            mret,
  output logic [XLEN-1:0] mstatus_next_c
);

  // Stack or unstack MIE through MPIE; M is the only privilege level so MPP stays M
  always_comb begin
    mstatus_next_c = mstatus;
    if (mret) begin
      mstatus_next_c[MSTATUS_MIE_BIT]  = mstatus[MSTATUS_MPIE_BIT];
      mstatus_next_c[MSTATUS_MPIE_BIT] = 1'b1;
    end else begin
      mstatus_next_c[MSTATUS_MPIE_BIT] = mstatus[MSTATUS_MIE_BIT];
      mstatus_next_c[MSTATUS_MIE_BIT]  = 1'b0;
    end
    mstatus_next_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
  end

endmodule

// File: rtl/clint_trap_ctrl.sv
// Machine-mode trap/mret sequencer driving the CSR file's CLINT write port.
// Build macro CLINT_VECTORED_EN: vectored mtvec dispatch for interrupts.
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = CLINT_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_id,
  input  logic            mret_id,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] pc_id,
  input  logic            csr_we_ex,
  input  logic [XLEN-1:0] clint_csr_mstatus,
  input  logic [XLEN-1:0] clint_csr_mepc,
  input  logic [XLEN-1:0] clint_csr_mtvec,
  input  logic            interrupt_enable,
  output logic            we_clint,
  output logic [11:0]     wa_clint,
  output logic [XLEN-1:0] wd_clint,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  clint_state_e    state, state_next;
  logic [XLEN-1:0] epc, cause;
  logic            kind_mret;

  logic            cap_en;
  logic [XLEN-1:0] cap_cause;
  logic            cap_mret;
  logic [XLEN-1:0] mstatus_next;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_target;

  clint_mstatus_update #(.XLEN(XLEN)) u_mstatus_update (
    .mstatus        (clint_csr_mstatus),
    .mret           (kind_mret),
    .mstatus_next_c (mstatus_next)
  );

  // State register and event capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      epc       <= '0;
      cause     <= '0;
      kind_mret <= 1'b0;
    end else begin
      state <= state_next;
      if (cap_en) begin
        epc       <= pc_id;
        cause     <= cap_cause;
        kind_mret <= cap_mret;
      end
    end
  end

  // Trap target from live mtvec, optionally vectored for interrupts
  always_comb begin
    mtvec_base  = clint_csr_mtvec & ALIGN_MASK;
    trap_target = mtvec_base;
`ifdef CLINT_VECTORED_EN
    if (cause[XLEN-1] && (clint_csr_mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
      trap_target = mtvec_base + XLEN'({cause[XLEN-2:0], 2'b00});
    end
`endif
  end

  // Next state and outputs; a write state stalls in place while EX owns the port
  always_comb begin
    state_next     = state;
    we_clint       = 1'b0;
    wa_clint       = 12'h000;
    wd_clint       = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cap_en         = 1'b0;
    cap_cause      = '0;
    cap_mret       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rst) begin
          if (ext_irq && interrupt_enable) begin
            cap_en     = 1'b1;
            cap_cause  = XLEN'(MCAUSE_EXT_IRQ);
            stall      = 1'b1;
            state_next = ST_T_MEPC;
          end else if (ecall_id) begin
            cap_en     = 1'b1;
            cap_cause  = XLEN'(MCAUSE_ECALL_M);
            stall      = 1'b1;
            state_next = ST_T_MEPC;
          end else if (mret_id) begin
            cap_en     = 1'b1;
            cap_mret   = 1'b1;
            stall      = 1'b1;
            state_next = ST_R_MSTATUS;
          end
        end
      end

      ST_T_MEPC: begin
        stall = 1'b1;
        if (!csr_we_ex) begin
          we_clint   = 1'b1;
          wa_clint   = CSR_MEPC;
          wd_clint   = epc & ALIGN_MASK;
          state_next = ST_T_MCAUSE;
        end
      end

      ST_T_MCAUSE: begin
        stall = 1'b1;
        if (!csr_we_ex) begin
          we_clint   = 1'b1;
          wa_clint   = CSR_MCAUSE;
          wd_clint   = cause;
          state_next = ST_T_MSTATUS;
        end
      end

      ST_T_MSTATUS, ST_R_MSTATUS: begin
        stall = 1'b1;
        if (!csr_we_ex) begin
          we_clint   = 1'b1;
          wa_clint   = CSR_MSTATUS;
          wd_clint   = mstatus_next;
          state_next = ST_REDIRECT;
        end
      end

      ST_REDIRECT: begin
        stall          = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = kind_mret ? (clint_csr_mepc & ALIGN_MASK) : trap_target;
        state_next     = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/clint_trap_ctrl.md
Name: clint_trap_ctrl

Overview:
Machine-mode trap sequencer sitting beside the ID-stage CSR register file. It accepts ecall, mret and external-interrupt events, then drives the CSR file's single CLINT write port (we_clint/wa_clint/wd_clint) over several cycles to update mepc, mcause and mstatus. It then issues a one-cycle PC redirect to mtvec or mepc. It stalls the pipeline for the whole sequence and yields the write port to EX-stage CSR writes, which always win.

Parameters:
XLEN, 32, data width of CSR values and PCs
MCAUSE_EXT_IRQ, 32'h8000_000B, mcause written for a machine external interrupt
MCAUSE_ECALL_M, 32'h0000_000B, mcause written for ecall from M-mode

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ecall_id  in  1  ecall decoded in ID this cycle
mret_id  in  1  mret decoded in ID this cycle
ext_irq  in  1  level-sensitive machine external interrupt request
pc_id  in  XLEN  PC of the instruction currently in ID
csr_we_ex  in  1  EX-stage CSR write active; has priority on the CSR write port
clint_csr_mstatus  in  XLEN  live mstatus from the CSR file
clint_csr_mepc  in  XLEN  live mepc
clint_csr_mtvec  in  XLEN  live mtvec
interrupt_enable  in  1  mstatus.MIE from the CSR file
we_clint  out  1  CSR write enable
wa_clint  out  12  CSR write address
wd_clint  out  XLEN  CSR write data
stall  out  1  freeze IF/ID while a sequence runs
flush  out  1  kill IF/ID contents, asserted in the redirect cycle
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset values: all outputs are 0, the state is IDLE, and the captured registers (cause, epc, kind) are 0.
- Reset asserted mid-sequence aborts to IDLE with no further writes. Partial CSR updates are not rolled back.
- States: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS, REDIRECT.
- Event priority, evaluated only in IDLE:
  - ext_irq && interrupt_enable first.
  - Then ecall_id.
  - Then mret_id.
  - ecall_id and mret_id both high: ecall taken, mret dropped.
- Acceptance in IDLE:
  - Capture epc=pc_id, cause, and kind (trap or mret).
  - Assert stall combinationally in that same cycle.
  - Trap: next state T_MEPC. Mret: next state R_MSTATUS.
- T_MEPC: we_clint=1, wa_clint=MEPC, wd_clint={epc[31:2],2'b00}.
- T_MCAUSE: we_clint=1, wa_clint=MCAUSE, wd_clint=cause.
- T_MSTATUS (read-modify-write of live clint_csr_mstatus):
  - MPIE(bit7) <= MIE(bit3).
  - MIE <= 0.
  - MPP(bits12:11) <= 2'b11.
  - All other bits unchanged.
- R_MSTATUS: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11, all other bits unchanged.
- Write-port conflict: in any write state with csr_we_ex=1, the state holds and we_clint is driven 0 that cycle. The write is retried next cycle, so each write lands exactly once.
- REDIRECT:
  - redirect_valid=1 and flush=1 for exactly one cycle.
  - Trap: redirect_pc = {mtvec[31:2],2'b00}. Mret: redirect_pc = {mepc[31:2],2'b00}.
  - mtvec and mepc are read live in this cycle.
  - Next state is IDLE.
- stall is 1 from the acceptance cycle through REDIRECT inclusive. It is 0 in IDLE with no event.
- Latency with no conflicts:
  - Trap accepted at T: writes at T+1..T+3, redirect at T+4, new event acceptable at T+5.
  - Mret: write at T+1, redirect at T+2.
- Events arriving in non-IDLE states are ignored. ext_irq is not latched; if it is still high and enabled on return to IDLE, it is taken.
- Interrupts are self-masked after entry because MIE is cleared.

Optional Feature:
- Macro CLINT_VECTORED_EN.
- Defined: for an interrupt trap with mtvec[1:0]==2'b01, redirect_pc = {mtvec[31:2],2'b00} + 4*cause[30:0]. Ecall and all other cases still use the base address.
- Undefined: direct mode only; mtvec[1:0] is ignored.

Decomposition:
- Shared package holds:
  - CSR address constants MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MIE 12'h304, MSCRATCH 12'h340.
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
  - mcause codes.
  - The state enum.
- Natural sub-module: clint_mstatus_update. It is combinational trap/mret mstatus next-value logic, reused by the CSR file if needed.

Test Plan:
- ecall_id=1, pc_id=32'h0000_0100, mtvec=32'h0000_0200, mstatus=32'h8 -> writes MEPC=0x100, MCAUSE=0xB, MSTATUS=0x1880 on T+1..T+3; redirect_pc=0x200 at T+4; stall high T..T+4.
- mret_id=1, mepc=0x104, mstatus=0x1880 -> T+1 writes MSTATUS=0x1888; T+2 redirect_pc=0x104 with flush=1.
- ext_irq=1 with interrupt_enable=1, pc_id=0x40 -> MCAUSE=0x8000_000B, MEPC=0x40. Repeat with interrupt_enable=0 -> no sequence, stall=0.
- Trap sequence with csr_we_ex=1 during T+2 -> we_clint=0 at T+2; MCAUSE written at T+3; redirect at T+5; exactly three CLINT writes in total.
- ext_irq, ecall_id and mret_id all high in one cycle -> interrupt taken. Then ecall_id and mret_id together -> ecall taken.
- rst pulsed during T_MCAUSE -> outputs 0 immediately, state IDLE, no redirect. With CLINT_VECTORED_EN, mtvec=0x201 and an interrupt -> redirect_pc=0x22C.
